cdb_writeback_stage: RTL and testbench
======================================

Name: cdb_writeback_stage

Overview:
- Sits directly downstream of ex_stage and consumes its two CDB broadcasts, cdb_0 and cdb_1.
- Registers both broadcasts once, then drives the PRF write ports and the ROB completion ports.
- Runs one branch-recovery FSM per thread. Each FSM generates the mispredict_0/mispredict_1 pulses that flush ex_stage, and a held fetch redirect.

Parameters:
XLEN, 64, datapath/PC width
PRF_BITS, `PRF_BITS, physical register index width
ROB_BITS, `ROB_BITS, ROB index width (ROB depth = 2**ROB_BITS)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (reset==0 resets)
cdb_0, cdb_1  in  CDB  broadcasts from ex_stage; when mispredict=1, FU_result carries the corrected PC
rob_head_0, rob_head_1  in  ROB_BITS  per-thread ROB head, used for age comparison
redirect_ack_0, redirect_ack_1  in  1  fetch accepted the redirect for that thread
prf_wr_en_0/1  out  1  PRF write enable, one per CDB lane
prf_wr_idx_0/1  out  PRF_BITS  PRF write index
prf_wr_data_0/1  out  XLEN  PRF write data
rob_cmpl_valid_0/1  out  1  ROB completion strobe, one per lane
rob_cmpl_idx_0/1  out  ROB_BITS  ROB index to mark complete
rob_cmpl_thread_0/1  out  1  thread of the completing instruction
mispredict_0, mispredict_1  out  1  one-cycle flush pulse per thread (feeds ex_stage)
redirect_valid_0/1  out  1  redirect request per thread
redirect_pc_0/1  out  XLEN  corrected fetch PC per thread
recovering_0/1  out  1  thread is in FLUSH or REDIRECT (used to stall issue)

Behaviour:
- Reset (async, reset==0):
  - all outputs 0;
  - both FSMs in IDLE;
  - pending ROB index and pending PC registers cleared;
  - an in-flight redirect is abandoned without waiting for ack.
- Writeback lanes: lane k is fully independent.
  - Sampling cdb_k.valid=1 at posedge N gives, during cycle N+1: prf_wr_en_k=1, prf_wr_idx_k=PRN, prf_wr_data_k=FU_result, rob_cmpl_valid_k=1, rob_cmpl_idx_k=ROB_index, rob_cmpl_thread_k=thread_ID.
  - Latency is exactly 1 cycle.
  - Mispredicting branches are written and completed like any other entry.
  - No filtering is performed; stale younger results are the ROB's responsibility.
- Age: dist(idx,t) = (idx - rob_head_t) mod 2**ROB_BITS, computed unsigned in ROB_BITS. A smaller dist is older.
- Per-thread candidate:
  - Candidates are the CDB lanes with valid=1, mispredict=1 and thread_ID=t.
  - If two candidates exist, the one with the smaller dist wins.
  - On equal dist (same ROB index), lane 0 wins.
- FSM per thread, states IDLE, FLUSH, REDIRECT:
  - IDLE: a candidate is present -> FLUSH; latch pend_rob=ROB_index and pend_pc=FU_result.
  - FLUSH: lasts exactly one cycle with mispredict_t=1, then -> REDIRECT.
  - REDIRECT: redirect_valid_t=1 and redirect_pc_t=pend_pc, held stable until redirect_ack_t=1 is sampled, then -> IDLE.
  - Ack in the first REDIRECT cycle is legal and gives a 1-cycle REDIRECT.
  - Ack while not in REDIRECT is ignored.
  - A new candidate while in FLUSH or REDIRECT:
    - older than pend_rob (dist strictly smaller): -> FLUSH, re-latch pend_rob and pend_pc, pulse mispredict_t again;
    - otherwise: ignored.
  - Ack and an older candidate in the same cycle: the candidate wins -> FLUSH.
- recovering_t = (state != IDLE).
- Thread 0 and thread 1 FSMs are independent; simultaneous events on both threads are each handled in full.
- All outputs are registered; there is no combinational path from any input to any output.

Decomposition:
- Add to sys_defs: enum RECOVERY_STATE {RCV_IDLE, RCV_FLUSH, RCV_REDIRECT}.
- Reuse the existing CDB typedef.
- Sub-module thread_recovery_fsm, instantiated twice. It holds the state, pend_rob and pend_pc, and performs the age compare for its thread.
- The two writeback lanes are plain registers in the top module.

Test Plan:
1. cdb_0{valid=1, PRN=5, ROB=3, thread=0, FU_result=7} for 1 cycle -> next cycle prf_wr_en_0=1, idx=5, data=7, rob_cmpl_valid_0=1, idx=3; all deasserted the cycle after.
2. Thread 0 mispredict: cdb_1{mispredict=1, ROB=3, FU_result=64'hAAAA_AAAA_AAAA_AABA}, rob_head_0=0; ack asserted 3 cycles later -> mispredict_0 high exactly 1 cycle; redirect_valid_0 high with that PC until ack; IDLE the next cycle; mispredict_1 stays 0.
3. Same-cycle thread 1 mispredicts: ROB 30 on cdb_0 and ROB 2 on cdb_1, rob_head_1=28 (ROB_BITS=5) -> ROB 30 chosen (dist 2 vs 6); redirect_pc_1 = cdb_0.FU_result.
4. During REDIRECT for ROB 10 (head 8): mispredict ROB 12 -> ignored, PC unchanged. Then mispredict ROB 9 -> new mispredict_0 pulse; redirect_pc_0 updated.
5. Thread 0 and thread 1 mispredict on cdb_0 and cdb_1 in the same cycle -> both mispredict pulses in the same cycle; each redirect is independent; PRF writes occur on both lanes.
6. reset driven low mid-REDIRECT, between clock edges -> all outputs 0 immediately; after release, recovering_0=0 and a later ack has no effect.

Source files
------------

// File: rtl/cdb_writeback_stage_pkg.sv
// Shared types for the CDB writeback stage: CDB broadcast, registered lane payload,
// recovery FSM states and the ROB age helper.
package cdb_writeback_stage_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned PRF_BITS = 6;
  localparam int unsigned ROB_BITS = 5;

  typedef enum logic [1:0] {
    RCV_IDLE,
    RCV_FLUSH,
    RCV_REDIRECT
  } RECOVERY_STATE;

  typedef struct packed {
    logic                valid;
    logic                mispredict;
    logic                thread_ID;
    logic [PRF_BITS-1:0] PRN;
    logic [ROB_BITS-1:0] ROB_index;
    logic [XLEN-1:0]     FU_result;
  } CDB;

  typedef struct packed {
    logic                valid;
    logic                thread_ID;
    logic [PRF_BITS-1:0] PRN;
    logic [ROB_BITS-1:0] ROB_index;
    logic [XLEN-1:0]     data;
  } wb_lane_t;

  // Distance from the ROB head; wraps modulo the ROB depth, smaller means older.
  function automatic logic [ROB_BITS-1:0] rob_dist(input logic [ROB_BITS-1:0] idx,
                                                   input logic [ROB_BITS-1:0] head);
    return idx - head;
  endfunction

  function automatic wb_lane_t to_lane(input CDB c);
    wb_lane_t l;
    l.valid     = c.valid;
    l.thread_ID = c.thread_ID;
    l.PRN       = c.PRN;
    l.ROB_index = c.ROB_index;
    l.data      = c.FU_result;
    return l;
  endfunction

endpackage

// File: rtl/cdb_writeback_stage_if.sv
// Bundle of CDB inputs, PRF/ROB writeback outputs and per-thread recovery signals.
interface cdb_writeback_stage_if;
  import cdb_writeback_stage_pkg::*;

  CDB                  cdb_0;
  CDB                  cdb_1;
  logic [ROB_BITS-1:0] rob_head_0;
  logic [ROB_BITS-1:0] rob_head_1;
  logic                redirect_ack_0;
  logic                redirect_ack_1;

  logic                prf_wr_en_0;
  logic                prf_wr_en_1;
  logic [PRF_BITS-1:0] prf_wr_idx_0;
  logic [PRF_BITS-1:0] prf_wr_idx_1;
  logic [XLEN-1:0]     prf_wr_data_0;
  logic [XLEN-1:0]     prf_wr_data_1;
  logic                rob_cmpl_valid_0;
  logic                rob_cmpl_valid_1;
  logic [ROB_BITS-1:0] rob_cmpl_idx_0;
  logic [ROB_BITS-1:0] rob_cmpl_idx_1;
  logic                rob_cmpl_thread_0;
  logic                rob_cmpl_thread_1;
  logic                mispredict_0;
  logic                mispredict_1;
  logic                redirect_valid_0;
  logic                redirect_valid_1;
  logic [XLEN-1:0]     redirect_pc_0;
  logic [XLEN-1:0]     redirect_pc_1;
  logic                recovering_0;
  logic                recovering_1;

  modport slave (
    input  cdb_0, cdb_1, rob_head_0, rob_head_1, redirect_ack_0, redirect_ack_1,
    output prf_wr_en_0, prf_wr_en_1, prf_wr_idx_0, prf_wr_idx_1,
    output prf_wr_data_0, prf_wr_data_1,
    output rob_cmpl_valid_0, rob_cmpl_valid_1, rob_cmpl_idx_0, rob_cmpl_idx_1,
    output rob_cmpl_thread_0, rob_cmpl_thread_1,
    output mispredict_0, mispredict_1, redirect_valid_0, redirect_valid_1,
    output redirect_pc_0, redirect_pc_1, recovering_0, recovering_1
  );

  modport master (
    output cdb_0, cdb_1, rob_head_0, rob_head_1, redirect_ack_0, redirect_ack_1,
    input  prf_wr_en_0, prf_wr_en_1, prf_wr_idx_0, prf_wr_idx_1,
    input  prf_wr_data_0, prf_wr_data_1,
    input  rob_cmpl_valid_0, rob_cmpl_valid_1, rob_cmpl_idx_0, rob_cmpl_idx_1,
    input  rob_cmpl_thread_0, rob_cmpl_thread_1,
    input  mispredict_0, mispredict_1, redirect_valid_0, redirect_valid_1,
    input  redirect_pc_0, redirect_pc_1, recovering_0, recovering_1
  );

endinterface

// File: rtl/cdb_writeback_stage_thread_recovery_fsm.sv
// Branch-recovery FSM for one thread: picks the oldest mispredicting lane, pulses a flush,
// then holds a fetch redirect until acknowledged.
module thread_recovery_fsm
  import cdb_writeback_stage_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_cand_0,
  input  logic [ROB_BITS-1:0] i_rob_0,
  input  logic [XLEN-1:0]     i_pc_0,
  input  logic                i_cand_1,
  input  logic [ROB_BITS-1:0] i_rob_1,
  input  logic [XLEN-1:0]     i_pc_1,
  input  logic [ROB_BITS-1:0] i_rob_head,
  input  logic                i_redirect_ack,
  output logic                o_mispredict,
  output logic                o_redirect_valid,
  output logic [XLEN-1:0]     o_redirect_pc,
  output logic                o_recovering
);

  RECOVERY_STATE       r_state, w_state_nxt;
  logic [ROB_BITS-1:0] r_pend_rob, w_pend_rob_nxt;
  logic [XLEN-1:0]     r_pend_pc, w_pend_pc_nxt;

  logic [ROB_BITS-1:0] w_dist_0, w_dist_1, w_dist_pend, w_cand_dist, w_cand_rob;
  logic [XLEN-1:0]     w_cand_pc;
  logic                w_sel_1, w_cand, w_older;

  assign w_dist_0    = rob_dist(i_rob_0, i_rob_head);
  assign w_dist_1    = rob_dist(i_rob_1, i_rob_head);
  assign w_dist_pend = rob_dist(r_pend_rob, i_rob_head);

  // Lane 1 wins only when strictly older, so equal distances fall to lane 0.
  assign w_sel_1     = i_cand_1 & (~i_cand_0 | (w_dist_1 < w_dist_0));
  assign w_cand      = i_cand_0 | i_cand_1;
  assign w_cand_rob  = w_sel_1 ? i_rob_1  : i_rob_0;
  assign w_cand_pc   = w_sel_1 ? i_pc_1   : i_pc_0;
  assign w_cand_dist = w_sel_1 ? w_dist_1 : w_dist_0;
  assign w_older     = w_cand & (w_cand_dist < w_dist_pend);

  always_comb begin
    w_state_nxt    = r_state;
    w_pend_rob_nxt = r_pend_rob;
    w_pend_pc_nxt  = r_pend_pc;
    case (r_state)
      RCV_IDLE: begin
        if (w_cand) begin
          w_state_nxt    = RCV_FLUSH;
          w_pend_rob_nxt = w_cand_rob;
          w_pend_pc_nxt  = w_cand_pc;
        end
      end
      RCV_FLUSH: begin
        if (w_older) begin
          w_pend_rob_nxt = w_cand_rob;
          w_pend_pc_nxt  = w_cand_pc;
        end else begin
          w_state_nxt = RCV_REDIRECT;
        end
      end
      RCV_REDIRECT: begin
        // An older mispredict takes priority over a same-cycle ack.
        if (w_older) begin
          w_state_nxt    = RCV_FLUSH;
          w_pend_rob_nxt = w_cand_rob;
          w_pend_pc_nxt  = w_cand_pc;
        end else if (i_redirect_ack) begin
          w_state_nxt = RCV_IDLE;
        end
      end
      default: w_state_nxt = RCV_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= RCV_IDLE;
      r_pend_rob <= '0;
      r_pend_pc  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_rob <= w_pend_rob_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
    end
  end

  assign o_mispredict     = (r_state == RCV_FLUSH);
  assign o_redirect_valid = (r_state == RCV_REDIRECT);
  assign o_redirect_pc    = o_redirect_valid ? r_pend_pc : '0;
  assign o_recovering     = (r_state != RCV_IDLE);

endmodule

// File: rtl/cdb_writeback_stage.sv
// Writeback stage: registers both CDB lanes onto the PRF/ROB ports and runs one
// branch-recovery FSM per thread.
module cdb_writeback_stage
  import cdb_writeback_stage_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  cdb_writeback_stage_if.slave bus
);

  wb_lane_t r_lane_0, r_lane_1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lane_0 <= '0;
      r_lane_1 <= '0;
    end else begin
      r_lane_0 <= to_lane(bus.cdb_0);
      r_lane_1 <= to_lane(bus.cdb_1);
    end
  end

  assign bus.prf_wr_en_0       = r_lane_0.valid;
  assign bus.prf_wr_idx_0      = r_lane_0.PRN;
  assign bus.prf_wr_data_0     = r_lane_0.data;
  assign bus.rob_cmpl_valid_0  = r_lane_0.valid;
  assign bus.rob_cmpl_idx_0    = r_lane_0.ROB_index;
  assign bus.rob_cmpl_thread_0 = r_lane_0.thread_ID;

  assign bus.prf_wr_en_1       = r_lane_1.valid;
  assign bus.prf_wr_idx_1      = r_lane_1.PRN;
  assign bus.prf_wr_data_1     = r_lane_1.data;
  assign bus.rob_cmpl_valid_1  = r_lane_1.valid;
  assign bus.rob_cmpl_idx_1    = r_lane_1.ROB_index;
  assign bus.rob_cmpl_thread_1 = r_lane_1.thread_ID;

  logic w_mp_lane_0, w_mp_lane_1;
  logic w_c0_t0, w_c1_t0, w_c0_t1, w_c1_t1;

  assign w_mp_lane_0 = bus.cdb_0.valid & bus.cdb_0.mispredict;
  assign w_mp_lane_1 = bus.cdb_1.valid & bus.cdb_1.mispredict;
  assign w_c0_t0     = w_mp_lane_0 & ~bus.cdb_0.thread_ID;
  assign w_c1_t0     = w_mp_lane_1 & ~bus.cdb_1.thread_ID;
  assign w_c0_t1     = w_mp_lane_0 &  bus.cdb_0.thread_ID;
  assign w_c1_t1     = w_mp_lane_1 &  bus.cdb_1.thread_ID;

  thread_recovery_fsm u_rcv_t0 (
    .i_clock          (clock),
    .i_reset_n        (reset),
    .i_cand_0         (w_c0_t0),
    .i_rob_0          (bus.cdb_0.ROB_index),
    .i_pc_0           (bus.cdb_0.FU_result),
    .i_cand_1         (w_c1_t0),
    .i_rob_1          (bus.cdb_1.ROB_index),
    .i_pc_1           (bus.cdb_1.FU_result),
    .i_rob_head       (bus.rob_head_0),
    .i_redirect_ack   (bus.redirect_ack_0),
    .o_mispredict     (bus.mispredict_0),
    .o_redirect_valid (bus.redirect_valid_0),
    .o_redirect_pc    (bus.redirect_pc_0),
    .o_recovering     (bus.recovering_0)
  );

  thread_recovery_fsm u_rcv_t1 (
    .i_clock          (clock),
    .i_reset_n        (reset),
    .i_cand_0         (w_c0_t1),
    .i_rob_0          (bus.cdb_0.ROB_index),
    .i_pc_0           (bus.cdb_0.FU_result),
    .i_cand_1         (w_c1_t1),
    .i_rob_1          (bus.cdb_1.ROB_index),
    .i_pc_1           (bus.cdb_1.FU_result),
    .i_rob_head       (bus.rob_head_1),
    .i_redirect_ack   (bus.redirect_ack_1),
    .o_mispredict     (bus.mispredict_1),
    .o_redirect_valid (bus.redirect_valid_1),
    .o_redirect_pc    (bus.redirect_pc_1),
    .o_recovering     (bus.recovering_1)
  );

endmodule

// File: tb/tb_cdb_writeback_stage.sv
// Self-checking bench: lane writebacks go through a scoreboard, recovery behaviour is
// checked directly against hand-derived values.
module tb_cdb_writeback_stage;
  import cdb_writeback_stage_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cdb_writeback_stage_if bus ();

  cdb_writeback_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [PRF_BITS-1:0] prn;
    logic [ROB_BITS-1:0] rob;
    logic                thr;
    logic [XLEN-1:0]     data;
    int                  due;
  } wb_exp_t;

  wb_exp_t sb_q[2][$];

  localparam logic [63:0] PcT2 = 64'hAAAA_AAAA_AAAA_AABA;
  localparam logic [63:0] PcA  = 64'h0000_0000_0000_1000;
  localparam logic [63:0] PcB  = 64'h0000_0000_0000_2000;
  localparam logic [63:0] PcC  = 64'h0000_0000_0000_3000;
  localparam logic [63:0] PcD  = 64'h0000_0000_0000_4000;
  localparam logic [63:0] PcE  = 64'h0000_0000_0000_5000;
  localparam logic [63:0] PcF  = 64'h0000_0000_0000_6000;
  localparam logic [63:0] PcG  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] PcH  = 64'h5555_6666_7777_8888;
  localparam logic [63:0] PcI  = 64'hDEAD_BEEF_0000_0004;
  localparam logic [63:0] Pc30 = 64'h0000_0000_0003_0030;
  localparam logic [63:0] Pc02 = 64'h0000_0000_0002_0002;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic CDB mk(input logic mp, input logic thr, input int prn, input int rob,
                            input logic [63:0] res);
    CDB c;
    c.valid      = 1'b1;
    c.mispredict = mp;
    c.thread_ID  = thr;
    c.PRN        = prn[PRF_BITS-1:0];
    c.ROB_index  = rob[ROB_BITS-1:0];
    c.FU_result  = res;
    return c;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int lane, input CDB c);
    wb_exp_t e;
    if (c.valid) begin
      e.prn  = c.PRN;
      e.rob  = c.ROB_index;
      e.thr  = c.thread_ID;
      e.data = c.FU_result;
      e.due  = cyc + 1;
      sb_q[lane].push_back(e);
    end
  endtask

  task automatic send(input CDB c0, input CDB c1);
    bus.cdb_0 = c0;
    bus.cdb_1 = c1;
    push(0, c0);
    push(1, c1);
    tick();
    bus.cdb_0 = '0;
    bus.cdb_1 = '0;
  endtask

  task automatic lane_mon(input int lane, input logic en, input logic [PRF_BITS-1:0] idx,
                          input logic [XLEN-1:0] data, input logic cv,
                          input logic [ROB_BITS-1:0] ridx, input logic thr);
    wb_exp_t e;
    if (sb_q[lane].size() > 0 && sb_q[lane][0].due == cyc) begin
      e = sb_q[lane].pop_front();
      check_eq($sformatf("lane%0d_wr_en", lane), en, 1'b1);
      check_eq($sformatf("lane%0d_wr_idx", lane), idx, e.prn);
      check_eq($sformatf("lane%0d_wr_data", lane), data, e.data);
      check_eq($sformatf("lane%0d_cmpl_valid", lane), cv, 1'b1);
      check_eq($sformatf("lane%0d_cmpl_idx", lane), ridx, e.rob);
      check_eq($sformatf("lane%0d_cmpl_thread", lane), thr, e.thr);
    end else if (en || cv) begin
      check_eq($sformatf("lane%0d_spurious", lane), {en, cv}, 2'b00);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      lane_mon(0, bus.prf_wr_en_0, bus.prf_wr_idx_0, bus.prf_wr_data_0, bus.rob_cmpl_valid_0,
               bus.rob_cmpl_idx_0, bus.rob_cmpl_thread_0);
      lane_mon(1, bus.prf_wr_en_1, bus.prf_wr_idx_1, bus.prf_wr_data_1, bus.rob_cmpl_valid_1,
               bus.rob_cmpl_idx_1, bus.rob_cmpl_thread_1);
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wr_en0"}, bus.prf_wr_en_0, 1'b0);
    check_eq({tag, "_wr_en1"}, bus.prf_wr_en_1, 1'b0);
    check_eq({tag, "_cmpl0"}, bus.rob_cmpl_valid_0, 1'b0);
    check_eq({tag, "_cmpl1"}, bus.rob_cmpl_valid_1, 1'b0);
    check_eq({tag, "_data0"}, bus.prf_wr_data_0, 64'h0);
    check_eq({tag, "_mp0"}, bus.mispredict_0, 1'b0);
    check_eq({tag, "_mp1"}, bus.mispredict_1, 1'b0);
    check_eq({tag, "_rv0"}, bus.redirect_valid_0, 1'b0);
    check_eq({tag, "_rv1"}, bus.redirect_valid_1, 1'b0);
    check_eq({tag, "_pc0"}, bus.redirect_pc_0, 64'h0);
    check_eq({tag, "_pc1"}, bus.redirect_pc_1, 64'h0);
    check_eq({tag, "_rec0"}, bus.recovering_0, 1'b0);
    check_eq({tag, "_rec1"}, bus.recovering_1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cdb_0          = '0;
    bus.cdb_1          = '0;
    bus.rob_head_0     = '0;
    bus.rob_head_1     = '0;
    bus.redirect_ack_0 = 1'b0;
    bus.redirect_ack_1 = 1'b0;
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    tick();

    // 1: plain writeback on lane 0, one-cycle latency then deassert.
    send(mk(1'b0, 1'b0, 5, 3, 64'd7), '0);
    check_eq("t1_mp0", bus.mispredict_0, 1'b0);
    tick();
    check_eq("t1_wr_en0_off", bus.prf_wr_en_0, 1'b0);
    check_eq("t1_cmpl0_off", bus.rob_cmpl_valid_0, 1'b0);

    // 2: thread 0 mispredict on lane 1, ack three cycles later.
    bus.rob_head_0 = 5'd0;
    send('0, mk(1'b1, 1'b0, 9, 3, PcT2));
    check_eq("t2_mp0_pulse", bus.mispredict_0, 1'b1);
    check_eq("t2_rv0_flush", bus.redirect_valid_0, 1'b0);
    check_eq("t2_rec0_flush", bus.recovering_0, 1'b1);
    check_eq("t2_mp1", bus.mispredict_1, 1'b0);
    tick();
    check_eq("t2_mp0_end", bus.mispredict_0, 1'b0);
    check_eq("t2_rv0", bus.redirect_valid_0, 1'b1);
    check_eq("t2_pc0", bus.redirect_pc_0, PcT2);
    tick();
    check_eq("t2_rv0_hold", bus.redirect_valid_0, 1'b1);
    check_eq("t2_pc0_hold", bus.redirect_pc_0, PcT2);
    bus.redirect_ack_0 = 1'b1;
    tick();
    bus.redirect_ack_0 = 1'b0;
    check_eq("t2_rv0_idle", bus.redirect_valid_0, 1'b0);
    check_eq("t2_rec0_idle", bus.recovering_0, 1'b0);

    // 3: same-cycle thread 1 candidates across the ROB wrap: 30 is older than 2 from head 28.
    bus.rob_head_1 = 5'd28;
    send(mk(1'b1, 1'b1, 10, 30, Pc30), mk(1'b1, 1'b1, 11, 2, Pc02));
    check_eq("t3_mp1", bus.mispredict_1, 1'b1);
    check_eq("t3_mp0", bus.mispredict_0, 1'b0);
    tick();
    check_eq("t3_pc1", bus.redirect_pc_1, Pc30);
    bus.redirect_ack_1 = 1'b1;
    tick();
    bus.redirect_ack_1 = 1'b0;
    check_eq("t3_rec1_idle", bus.recovering_1, 1'b0);

    // 4: younger mispredict ignored, older one re-flushes, older beats a same-cycle ack.
    bus.rob_head_0 = 5'd8;
    send(mk(1'b1, 1'b0, 12, 10, PcA), '0);
    tick();
    check_eq("t4_pc_a", bus.redirect_pc_0, PcA);
    send('0, mk(1'b1, 1'b0, 13, 12, PcB));
    check_eq("t4_young_mp0", bus.mispredict_0, 1'b0);
    check_eq("t4_young_rv0", bus.redirect_valid_0, 1'b1);
    check_eq("t4_young_pc", bus.redirect_pc_0, PcA);
    send(mk(1'b1, 1'b0, 14, 9, PcC), '0);
    check_eq("t4_old_mp0", bus.mispredict_0, 1'b1);
    check_eq("t4_old_rv0", bus.redirect_valid_0, 1'b0);
    tick();
    check_eq("t4_pc_c", bus.redirect_pc_0, PcC);
    bus.redirect_ack_0 = 1'b1;
    send('0, mk(1'b1, 1'b0, 15, 8, PcD));
    bus.redirect_ack_0 = 1'b0;
    check_eq("t4_ack_vs_old_mp0", bus.mispredict_0, 1'b1);
    tick();
    check_eq("t4_pc_d", bus.redirect_pc_0, PcD);
    bus.redirect_ack_0 = 1'b1;
    tick();
    bus.redirect_ack_0 = 1'b0;
    check_eq("t4_rec0_idle", bus.recovering_0, 1'b0);

    // Equal ROB index on both lanes: lane 0 wins; ack during FLUSH is ignored.
    send(mk(1'b1, 1'b0, 16, 20, PcE), mk(1'b1, 1'b0, 17, 20, PcF));
    bus.redirect_ack_0 = 1'b1;
    tick();
    bus.redirect_ack_0 = 1'b0;
    check_eq("tie_rv0", bus.redirect_valid_0, 1'b1);
    check_eq("tie_pc0", bus.redirect_pc_0, PcE);
    tick();
    check_eq("tie_rv0_hold", bus.redirect_valid_0, 1'b1);
    bus.redirect_ack_0 = 1'b1;
    tick();
    bus.redirect_ack_0 = 1'b0;
    check_eq("tie_rec0_idle", bus.recovering_0, 1'b0);

    // 5: both threads mispredict in the same cycle.
    bus.rob_head_0 = 5'd0;
    bus.rob_head_1 = 5'd0;
    send(mk(1'b1, 1'b0, 20, 5, PcG), mk(1'b1, 1'b1, 21, 7, PcH));
    check_eq("t5_mp0", bus.mispredict_0, 1'b1);
    check_eq("t5_mp1", bus.mispredict_1, 1'b1);
    tick();
    check_eq("t5_pc0", bus.redirect_pc_0, PcG);
    check_eq("t5_pc1", bus.redirect_pc_1, PcH);
    bus.redirect_ack_0 = 1'b1;
    tick();
    bus.redirect_ack_0 = 1'b0;
    check_eq("t5_rv0_done", bus.redirect_valid_0, 1'b0);
    check_eq("t5_rv1_still", bus.redirect_valid_1, 1'b1);
    bus.redirect_ack_1 = 1'b1;
    tick();
    bus.redirect_ack_1 = 1'b0;
    check_eq("t5_rv1_done", bus.redirect_valid_1, 1'b0);

    // 6: async reset mid-REDIRECT abandons the redirect.
    send(mk(1'b1, 1'b0, 22, 4, PcI), '0);
    tick();
    check_eq("t6_rv0_pre", bus.redirect_valid_0, 1'b1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_all_zero("t6_reset");
    @(negedge clock);
    reset = 1'b1;
    tick();
    bus.redirect_ack_0 = 1'b1;
    tick();
    bus.redirect_ack_0 = 1'b0;
    check_eq("t6_rec0", bus.recovering_0, 1'b0);
    check_eq("t6_rv0", bus.redirect_valid_0, 1'b0);
    check_eq("t6_mp0", bus.mispredict_0, 1'b0);

    tick();
    check_eq("sb_drain0", 64'(sb_q[0].size()), 64'd0);
    check_eq("sb_drain1", 64'(sb_q[1].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
